// File: rtl/csr_user_unit.sv
// User-level CSR file: U-mode trap CSRs, FP status CSRs and the CYCLE/TIME/INSTRET
// counters, serving CSRRW/CSRRS/CSRRC accesses with a registered one-cycle response.
module csr_user_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 64,
    parameter int TIME_DIV      = 1,
    parameter int FP_CSR_EN     = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic [11:0]           i_addr,
    input  logic [1:0]            i_op,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ack,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_fault,
    input  logic                  i_retire,
    input  logic                  i_fflags_we,
    input  logic [4:0]            i_fflags_set,
    output logic [2:0]            o_frm
);

    // Handshake: i_req is a one-cycle valid with no ready; every request is
    // accepted and answered by exactly one o_ack pulse on the following cycle.

    localparam logic [11:0] A_USTATUS  = 12'h000;
    localparam logic [11:0] A_FFLAGS   = 12'h001;
    localparam logic [11:0] A_FRM      = 12'h002;
    localparam logic [11:0] A_FCSR     = 12'h003;
    localparam logic [11:0] A_UIE      = 12'h004;
    localparam logic [11:0] A_UTVEC    = 12'h005;
    localparam logic [11:0] A_USCRATCH = 12'h040;
    localparam logic [11:0] A_UEPC     = 12'h041;
    localparam logic [11:0] A_UCAUSE   = 12'h042;
    localparam logic [11:0] A_UTVAL    = 12'h043;
    localparam logic [11:0] A_UIP      = 12'h044;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_TIME     = 12'hC01;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_TIMEH    = 12'hC81;
    localparam logic [11:0] A_INSTRETH = 12'hC82;

    localparam int PS_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [PS_W-1:0]          PS_LAST = PS_W'(TIME_DIV - 1);
    localparam logic [PS_W-1:0]          PS_ONE  = PS_W'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic                     FP_ON   = (FP_CSR_EN != 0);

    logic [DATA_WIDTH-1:0]    r_uscratch;
    logic [DATA_WIDTH-1:0]    r_uepc;
    logic [DATA_WIDTH-1:0]    r_ucause;
    logic [DATA_WIDTH-1:0]    r_utval;
    logic [DATA_WIDTH-1:0]    r_utvec;
    logic [4:0]               r_fflags;
    logic [2:0]               r_frm;
    logic [COUNTER_WIDTH-1:0] r_cycle;
    logic [COUNTER_WIDTH-1:0] r_time;
    logic [COUNTER_WIDTH-1:0] r_instret;
    logic [PS_W-1:0]          r_prescale;
    logic                     r_ack;
    logic                     r_fault;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic [63:0]           w_cycle64;
    logic [63:0]           w_time64;
    logic [63:0]           w_instret64;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;
    logic [DATA_WIDTH-1:0] w_utvec_new;
    logic                  w_impl;
    logic                  w_fault;
    logic                  w_wr;
    logic                  w_tick;

    assign w_cycle64   = 64'(r_cycle);
    assign w_time64    = 64'(r_time);
    assign w_instret64 = 64'(r_instret);
    assign w_tick      = (r_prescale == PS_LAST);

    always_comb begin
        w_old  = '0;
        w_impl = 1'b0;
        case (i_addr)
            A_USTATUS, A_UIE, A_UIP: w_impl = 1'b1;
            A_UTVEC:    begin w_impl = 1'b1; w_old = r_utvec;    end
            A_USCRATCH: begin w_impl = 1'b1; w_old = r_uscratch; end
            A_UEPC:     begin w_impl = 1'b1; w_old = r_uepc;     end
            A_UCAUSE:   begin w_impl = 1'b1; w_old = r_ucause;   end
            A_UTVAL:    begin w_impl = 1'b1; w_old = r_utval;    end
            A_FFLAGS:   begin w_impl = FP_ON; w_old = DATA_WIDTH'(r_fflags); end
            A_FRM:      begin w_impl = FP_ON; w_old = DATA_WIDTH'(r_frm);    end
            A_FCSR:     begin w_impl = FP_ON; w_old = DATA_WIDTH'({r_frm, r_fflags}); end
            A_CYCLE:    begin w_impl = 1'b1; w_old = w_cycle64[31:0];    end
            A_TIME:     begin w_impl = 1'b1; w_old = w_time64[31:0];     end
            A_INSTRET:  begin w_impl = 1'b1; w_old = w_instret64[31:0];  end
            A_CYCLEH:   begin w_impl = 1'b1; w_old = w_cycle64[63:32];   end
            A_TIMEH:    begin w_impl = 1'b1; w_old = w_time64[63:32];    end
            A_INSTRETH: begin w_impl = 1'b1; w_old = w_instret64[63:32]; end
            default:    ;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (i_op)
            2'b01:   w_new = i_wdata;
            2'b10:   w_new = w_old | i_wdata;
            2'b11:   w_new = w_old & ~i_wdata;
            default: w_new = w_old;
        endcase
    end

    assign w_fault = !w_impl || (i_we && (i_addr[11:10] == 2'b11));
    assign w_wr    = i_req && !w_fault && i_we && (i_op != 2'b00);
    // Reserved MODE encodings keep the previous MODE; BASE always updates.
    assign w_utvec_new = {w_new[DATA_WIDTH-1:2],
                          (w_new[1:0] >= 2'd2) ? r_utvec[1:0] : w_new[1:0]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ack      <= 1'b0;
            r_fault    <= 1'b0;
            r_rdata    <= '0;
            r_uscratch <= '0;
            r_uepc     <= '0;
            r_ucause   <= '0;
            r_utval    <= '0;
            r_utvec    <= '0;
        end else begin
            r_ack   <= i_req;
            r_fault <= i_req && w_fault;
            if (i_req) begin
                r_rdata <= w_fault ? '0 : w_old;
            end
            if (w_wr) begin
                case (i_addr)
                    A_USCRATCH: r_uscratch <= w_new;
                    A_UEPC:     r_uepc     <= {w_new[DATA_WIDTH-1:2], 2'b00};
                    A_UCAUSE:   r_ucause   <= w_new;
                    A_UTVAL:    r_utval    <= w_new;
                    A_UTVEC:    r_utvec    <= w_utvec_new;
                    default:    ;
                endcase
            end
        end
    end

    // A CSR write to the flags overrides the FPU's accrued-exception update.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fflags <= '0;
            r_frm    <= '0;
        end else begin
            if (w_wr && (i_addr == A_FFLAGS)) begin
                r_fflags <= w_new[4:0];
            end else if (w_wr && (i_addr == A_FCSR)) begin
                r_fflags <= w_new[4:0];
            end else if (i_fflags_we && FP_ON) begin
                r_fflags <= r_fflags | i_fflags_set;
            end
            if (w_wr && (i_addr == A_FRM)) begin
                r_frm <= w_new[2:0];
            end else if (w_wr && (i_addr == A_FCSR)) begin
                r_frm <= w_new[7:5];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cycle    <= '0;
            r_time     <= '0;
            r_instret  <= '0;
            r_prescale <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_ONE;
            if (i_retire) begin
                r_instret <= r_instret + CNT_ONE;
            end
            if (w_tick) begin
                r_prescale <= '0;
                r_time     <= r_time + CNT_ONE;
            end else begin
                r_prescale <= r_prescale + PS_ONE;
            end
        end
    end

    assign o_ack   = r_ack;
    assign o_rdata = r_rdata;
    assign o_fault = r_fault;
    assign o_frm   = r_frm;

endmodule

// File: tb/tb_csr_user_unit.sv
// Randomised bench for csr_user_unit: two configurations share one clock and are
// exercised in turn against a behavioural CSR model kept in the bench.
module tb_csr_user_unit;

  logic        clk = 1'b0;
  logic        rst_x = 1'b1;
  bit          sel = 1'b0;
  logic        req = 1'b0;
  logic [11:0] addr = '0;
  logic [1:0]  op = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        retire = 1'b0;
  logic        fw = 1'b0;
  logic [4:0]  fset = '0;

  logic        rst0, rst1;
  logic        ack0, ack1, fault0, fault1;
  logic [31:0] rdata0, rdata1;
  logic [2:0]  frm0, frm1;
  logic        ack, fault;
  logic [31:0] rdata;
  logic [2:0]  frm;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int          m_cw, m_tdiv, m_fpen, m_ps;
  logic [63:0] m_cycle, m_time, m_instret;
  logic [31:0] m_uscratch, m_uepc, m_ucause, m_utval, m_utvec;
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;

  logic [11:0] addr_tab [0:19];

  // clock / reset
  always #5 clk = ~clk;
  assign rst0 = rst_x | sel;
  assign rst1 = rst_x | ~sel;

  csr_user_unit #(.DATA_WIDTH(32), .COUNTER_WIDTH(64), .TIME_DIV(1), .FP_CSR_EN(1)) dut0 (
    .i_clock(clk), .i_reset(rst0), .i_req(req), .i_addr(addr), .i_op(op), .i_we(we),
    .i_wdata(wdata), .o_ack(ack0), .o_rdata(rdata0), .o_fault(fault0), .i_retire(retire),
    .i_fflags_we(fw), .i_fflags_set(fset), .o_frm(frm0));

  csr_user_unit #(.DATA_WIDTH(32), .COUNTER_WIDTH(8), .TIME_DIV(4), .FP_CSR_EN(0)) dut1 (
    .i_clock(clk), .i_reset(rst1), .i_req(req), .i_addr(addr), .i_op(op), .i_we(we),
    .i_wdata(wdata), .o_ack(ack1), .o_rdata(rdata1), .o_fault(fault1), .i_retire(retire),
    .i_fflags_we(fw), .i_fflags_set(fset), .o_frm(frm1));

  assign ack   = sel ? ack1 : ack0;
  assign fault = sel ? fault1 : fault0;
  assign rdata = sel ? rdata1 : rdata0;
  assign frm   = sel ? frm1 : frm0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_mask();
    return (m_cw >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << m_cw) - 64'd1);
  endfunction

  task automatic model_reset();
    m_ps = 0; m_cycle = '0; m_time = '0; m_instret = '0;
    m_uscratch = '0; m_uepc = '0; m_ucause = '0; m_utval = '0; m_utvec = '0;
    m_fflags = '0; m_frm = '0;
  endtask

  task automatic model_read(input logic [11:0] a, output logic impl, output logic [31:0] v);
    impl = 1'b1;
    v = '0;
    case (a)
      12'h000, 12'h004, 12'h044: v = '0;
      12'h005: v = m_utvec;
      12'h040: v = m_uscratch;
      12'h041: v = m_uepc;
      12'h042: v = m_ucause;
      12'h043: v = m_utval;
      12'h001: begin impl = (m_fpen != 0); v = {27'd0, m_fflags}; end
      12'h002: begin impl = (m_fpen != 0); v = {29'd0, m_frm}; end
      12'h003: begin impl = (m_fpen != 0); v = {24'd0, m_frm, m_fflags}; end
      12'hC00: v = m_cycle[31:0];
      12'hC01: v = m_time[31:0];
      12'hC02: v = m_instret[31:0];
      12'hC80: v = m_cycle[63:32];
      12'hC81: v = m_time[63:32];
      12'hC82: v = m_instret[63:32];
      default: impl = 1'b0;
    endcase
    if (!impl) v = '0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] nv);
    case (a)
      12'h040: m_uscratch = nv;
      12'h041: m_uepc = nv & 32'hFFFF_FFFC;
      12'h042: m_ucause = nv;
      12'h043: m_utval = nv;
      12'h005: m_utvec = (nv[1:0] >= 2'd2) ? {nv[31:2], m_utvec[1:0]} : nv;
      12'h001: m_fflags = nv[4:0];
      12'h002: m_frm = nv[2:0];
      12'h003: begin m_fflags = nv[4:0]; m_frm = nv[7:5]; end
      default: ;
    endcase
  endtask

  // driver: one clock cycle with the given inputs, then compare against the model
  task automatic step(input logic r, input logic [11:0] a, input logic [1:0] o, input logic w,
                      input logic [31:0] d, input logic ret, input logic f, input logic [4:0] fs);
    logic        impl, exp_fault, wr;
    logic [31:0] old, nv, exp_rd;
    @(negedge clk);
    rst_x = 1'b0; req = r; addr = a; op = o; we = w; wdata = d;
    retire = ret; fw = f; fset = fs;
    model_read(a, impl, old);
    exp_fault = !impl || (w && (a[11:10] == 2'b11));
    exp_rd = exp_fault ? 32'd0 : old;
    wr = r && !exp_fault && w && (o != 2'b00);
    case (o)
      2'b01:   nv = d;
      2'b10:   nv = old | d;
      2'b11:   nv = old & ~d;
      default: nv = old;
    endcase
    m_cycle = (m_cycle + 64'd1) & cnt_mask();
    if (ret) m_instret = (m_instret + 64'd1) & cnt_mask();
    if (m_ps == m_tdiv - 1) begin
      m_ps = 0;
      m_time = (m_time + 64'd1) & cnt_mask();
    end else begin
      m_ps++;
    end
    if (f && m_fpen != 0) m_fflags = m_fflags | fs;
    if (wr) model_write(a, nv);
    @(posedge clk);
    #1;
    if (r) begin
      check("ack", {31'd0, ack}, 32'd1);
      check($sformatf("fault@%03h", a), {31'd0, fault}, {31'd0, exp_fault});
      check($sformatf("rdata@%03h", a), rdata, exp_rd);
    end else begin
      check("idle_ack", {31'd0, ack}, 32'd0);
    end
    check("frm", {29'd0, frm}, {29'd0, m_frm});
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, a, 2'b10, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
  endtask

  // reset with a request present: the request must be dropped
  task automatic do_reset();
    @(negedge clk);
    rst_x = 1'b1; req = 1'b1; addr = 12'h040; op = 2'b01; we = 1'b1; wdata = 32'h1234_5678;
    retire = 1'b1; fw = 1'b1; fset = 5'h1F;
    @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_frm", {29'd0, frm}, 32'd0);
    model_reset();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 3) != 0), addr_tab[$urandom_range(0, 19)],
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    addr_tab = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h040, 12'h041,
                 12'h042, 12'h043, 12'h044, 12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81,
                 12'hC82, 12'h7C0, 12'h006, 12'hC03};

    // phase 0: 64-bit counters, TIME_DIV=1, FP CSRs present
    sel = 1'b0; m_cw = 64; m_tdiv = 1; m_fpen = 1;
    model_reset();
    do_reset();
    // fflags: CSR write wins over a coincident FPU update, later updates accrue
    step(1'b1, 12'h001, 2'b01, 1'b1, 32'h10, 1'b0, 1'b1, 5'b00011);
    step(1'b0, 12'h000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1, 5'b00001);
    rd(12'h003);
    step(1'b1, 12'h040, 2'b01, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0);
    step(1'b1, 12'h040, 2'b10, 1'b1, 32'h0000_000F, 1'b0, 1'b0, 5'd0);
    rd(12'h040);
    step(1'b1, 12'h005, 2'b01, 1'b1, 32'h0000_1001, 1'b0, 1'b0, 5'd0);
    step(1'b1, 12'h005, 2'b01, 1'b1, 32'h0000_1003, 1'b0, 1'b0, 5'd0);
    step(1'b1, 12'h005, 2'b01, 1'b1, 32'h0000_2002, 1'b0, 1'b0, 5'd0);
    rd(12'h005);
    step(1'b1, 12'h041, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0);
    rd(12'h041);
    step(1'b1, 12'h003, 2'b01, 1'b1, 32'hFFFF_FFA5, 1'b0, 1'b0, 5'd0);
    rd(12'h002);
    step(1'b1, 12'hC00, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0);
    rd(12'hC00);
    rd(12'hC80);
    step(1'b1, 12'h7C0, 2'b10, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 12'h000, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0);
    rd(12'h000);
    random_phase(300);

    // phase 1: 8-bit counters, TIME_DIV=4, FP CSRs absent
    sel = 1'b1; m_cw = 8; m_tdiv = 4; m_fpen = 0;
    do_reset();
    idle(17);
    rd(12'hC01);
    do_reset();
    step(1'b0, 12'h000, 2'b00, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 12'h000, 2'b00, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0);
    step(1'b1, 12'hC02, 2'b10, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0);
    rd(12'hC02);
    step(1'b1, 12'h003, 2'b10, 1'b0, 32'd0, 1'b0, 1'b1, 5'h1F);
    step(1'b1, 12'h001, 2'b01, 1'b1, 32'h1F, 1'b0, 1'b0, 5'd0);
    idle(260);
    rd(12'hC00);
    rd(12'hC80);
    random_phase(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
